// File: rtl/data_packer.sv
// Width upsizer: packs RATIO narrow words into one wide word.
// Lane 0 of the packed word holds the oldest input word.
module data_packer #(
  parameter  int WIDTH       = 8,
  parameter  int RATIO       = 4,
  localparam int COUNT_WIDTH = $clog2(RATIO + 1)
) (
  input  logic                   clock,
  input  logic                   resetn,
  input  logic                   write_enable,
  input  logic [WIDTH-1:0]       write_data,
  input  logic                   write_last,
  output logic                   full,
  input  logic                   read_enable,
  output logic [WIDTH*RATIO-1:0] read_data,
  output logic [COUNT_WIDTH-1:0] read_count,
  output logic                   empty
);

  localparam int LANE_W = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam int DW     = WIDTH * RATIO;

  logic [DW-1:0]          acc_q, acc_d, acc_w;
  logic [LANE_W-1:0]      lane_q, lane_d;
  logic                   closed_q, closed_d;
  logic [DW-1:0]          out_data_q, out_data_d;
  logic [COUNT_WIDTH-1:0] out_cnt_q, out_cnt_d;
  logic                   out_valid_q, out_valid_d;

  logic                   wr, rd, done;
  logic [COUNT_WIDTH-1:0] filled;

  assign wr     = write_enable && !closed_q;
  assign rd     = read_enable && out_valid_q;
  assign filled = COUNT_WIDTH'(lane_q) + COUNT_WIDTH'(1);
  assign done   = (lane_q == LANE_W'(RATIO - 1)) || write_last;

  always_comb begin
    acc_w = acc_q;
    acc_w[lane_q*WIDTH +: WIDTH] = write_data;
  end

  always_comb begin
    acc_d       = acc_q;
    lane_d      = lane_q;
    closed_d    = closed_q;
    out_data_d  = out_data_q;
    out_cnt_d   = out_cnt_q;
    out_valid_d = out_valid_q;
    if (rd) begin
      out_valid_d = 1'b0;
    end
    // A closed word refills the output at the pop edge: no bubble.
    if (closed_q && rd) begin
      out_data_d  = acc_q;
      out_cnt_d   = filled;
      out_valid_d = 1'b1;
      acc_d       = '0;
      lane_d      = '0;
      closed_d    = 1'b0;
    end else if (wr) begin
      if (done) begin
        if (!out_valid_q || rd) begin
          out_data_d  = acc_w;
          out_cnt_d   = filled;
          out_valid_d = 1'b1;
          acc_d       = '0;
          lane_d      = '0;
        end else begin
          acc_d    = acc_w;
          closed_d = 1'b1;
        end
      end else begin
        acc_d  = acc_w;
        lane_d = lane_q + LANE_W'(1);
      end
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      acc_q       <= '0;
      lane_q      <= '0;
      closed_q    <= 1'b0;
      out_data_q  <= '0;
      out_cnt_q   <= '0;
      out_valid_q <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      lane_q      <= lane_d;
      closed_q    <= closed_d;
      out_data_q  <= out_data_d;
      out_cnt_q   <= out_cnt_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign full       = closed_q;
  assign empty      = !out_valid_q;
  assign read_data  = out_data_q;
  assign read_count = out_cnt_q;

endmodule
